md5_msg_padder: RTL

// - Producer side of the MD5 block interface: takes a byte stream for one message and emits
//   the padded message as 32-bit little-endian words, 16 per 512-bit block, for the MD5 core.
// - Applies RFC 1321 padding: 0x80 byte, zero fill to byte 56 mod 64, then 64-bit bit length, LSW first.

---
 rtl/md5_pkg.sv | 25 ++
 rtl/md5_word_packer.sv | 46 ++++
 rtl/md5_msg_padder.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/md5_pkg.sv
// Shared types and constants for the MD5 message padder.
package md5_pkg;

  typedef enum logic [2:0] {
    S_DATA,
    S_PAD,
    S_ZERO,
    S_LEN_LO,
    S_LEN_HI
  } state_e;

  localparam logic [7:0]        PAD_BYTE      = 8'h80;
  localparam int unsigned       WORDS_PER_BLK = 16;
  localparam int unsigned       IDX_W         = $clog2(WORDS_PER_BLK);
  localparam logic [IDX_W-1:0]  LEN_LO_IDX    = IDX_W'(14);
  localparam logic [IDX_W-1:0]  LEN_HI_IDX    = IDX_W'(15);

  // Little-endian insert: byte lane k occupies bits [8k+7:8k].
  function automatic logic [31:0] lane_insert(input logic [31:0] w,
                                              input logic [7:0]  b,
                                              input logic [1:0]  lane);
    return w | ({24'b0, b} << {lane, 3'b000});
  endfunction

endpackage

// File: rtl/md5_word_packer.sv
// Byte-lane assembler: collects message bytes into a little-endian word and
// offers the same partial word with the 0x80 pad byte at the current lane.
module md5_word_packer
  import md5_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_i,
  input  logic        clr_i,
  input  logic [7:0]  byte_i,
  output logic [1:0]  lane_o,
  output logic [31:0] word_o,
  output logic [31:0] pad_word_o
);

  logic [1:0]  lane_q, lane_d;
  logic [31:0] part_q, part_d;

  // Bytes above the current lane are always zero, so OR-insert is sufficient.
  assign word_o     = lane_insert(part_q, byte_i, lane_q);
  assign pad_word_o = lane_insert(part_q, PAD_BYTE, lane_q);
  assign lane_o     = lane_q;

  always_comb begin
    lane_d = lane_q;
    part_d = part_q;
    if (clr_i) begin
      lane_d = '0;
      part_d = '0;
    end else if (wr_i) begin
      lane_d = lane_q + 2'd1;
      part_d = (lane_q == 2'd3) ? '0 : word_o;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= '0;
      part_q <= '0;
    end else begin
      lane_q <= lane_d;
      part_q <= part_d;
    end
  end

endmodule

// File: rtl/md5_msg_padder.sv
// MD5 producer: turns a byte stream into RFC 1321 padded 32-bit words,
// 16 per block, with the 64-bit bit length in the last two words.
module md5_msg_padder
  import md5_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  input  logic             in_empty,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_word,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_blk_last,
  output logic             out_msg_last
);

  localparam logic [IDX_W-1:0] ZERO_END_IDX = LEN_LO_IDX - 1'b1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] nidx_q, nidx_d;

  logic             out_valid_q;
  logic [31:0]      out_word_q;
  logic [IDX_W-1:0] out_idx_q;
  logic             out_blk_last_q;
  logic             out_msg_last_q;

  logic [1:0]  lane;
  logic [31:0] pk_word, pk_pad;
  logic        out_free, in_ready_c, in_acc, byte_wr;
  logic        ld, ld_msg_last, msg_done;
  logic [31:0] ld_word;
  logic [63:0] len_bits;

  assign out_free = !out_valid_q || out_ready;
  assign len_bits = 64'({cnt_q, 3'b000});
  assign in_ready = rst_n && in_ready_c;

  md5_word_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_i       (byte_wr),
    .clr_i      (msg_done),
    .byte_i     (in_data),
    .lane_o     (lane),
    .word_o     (pk_word),
    .pad_word_o (pk_pad)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_DATA;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_DATA:   if (in_acc && in_last) state_d = S_PAD;
      S_PAD:    if (ld) state_d = (nidx_q == ZERO_END_IDX) ? S_LEN_LO : S_ZERO;
      // Pad at idx 14/15 falls through 15 and wraps; stopping at 13 yields the extra block.
      S_ZERO:   if (ld && nidx_q == ZERO_END_IDX) state_d = S_LEN_LO;
      S_LEN_LO: if (ld) state_d = S_LEN_HI;
      S_LEN_HI: if (ld) state_d = S_DATA;
      default:  state_d = S_DATA;
    endcase
  end

  always_comb begin
    in_ready_c  = 1'b0;
    in_acc      = 1'b0;
    byte_wr     = 1'b0;
    ld          = 1'b0;
    ld_word     = '0;
    ld_msg_last = 1'b0;
    msg_done    = 1'b0;
    unique case (state_q)
      S_DATA: begin
        // Completing a word needs the output register; stall only that beat.
        in_ready_c = !(lane == 2'd3 && !out_free);
        in_acc     = in_valid && in_ready_c;
        byte_wr    = in_acc && !(in_last && in_empty);
        ld         = byte_wr && (lane == 2'd3);
        ld_word    = pk_word;
      end
      S_PAD: begin
        ld      = out_free;
        ld_word = pk_pad;
      end
      S_ZERO: begin
        ld = out_free;
      end
      S_LEN_LO: begin
        ld      = out_free;
        ld_word = len_bits[31:0];
      end
      S_LEN_HI: begin
        ld          = out_free;
        ld_word     = len_bits[63:32];
        ld_msg_last = 1'b1;
        msg_done    = out_free;
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    nidx_d = nidx_q;
    if (msg_done)     cnt_d = '0;
    else if (byte_wr) cnt_d = cnt_q + 1'b1;
    if (ld)           nidx_d = nidx_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      nidx_q         <= '0;
      out_valid_q    <= 1'b0;
      out_word_q     <= '0;
      out_idx_q      <= '0;
      out_blk_last_q <= 1'b0;
      out_msg_last_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      nidx_q <= nidx_d;
      if (ld) begin
        out_valid_q    <= 1'b1;
        out_word_q     <= ld_word;
        out_idx_q      <= nidx_q;
        out_blk_last_q <= (nidx_q == LEN_HI_IDX);
        out_msg_last_q <= ld_msg_last;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid    = out_valid_q;
  assign out_word     = out_word_q;
  assign out_idx      = out_idx_q;
  assign out_blk_last = out_blk_last_q;
  assign out_msg_last = out_msg_last_q;

endmodule
